// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master.
// Frame layout: command byte, address, data (MSB first).
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 8 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_mem_master_ctrl_sclk_gen.sv
// Frame-bounded sclk divider: half-period of CLK_DIV clk cycles.
// Strobes mark the clk edge on which sclk rises or falls.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle,
  output logic sclk,
  output logic tick,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  assign tick     = en && (div == DIV_LAST);
  assign rise_stb = tick && toggle && !sclk;
  assign fall_stb = tick && toggle && sclk;

  // half-period counter; sclk parks low whenever disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      div  <= '0;
      sclk <= toggle ? ~sclk : 1'b0;
    end else begin
      div  <= div + DW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_master_ctrl.sv
// SPI mode-0 master issuing read/write frames to an SPI memory.
// Define SPI_CS_GAP_EN to enforce CS_GAP idle cycles between frames.
module spi_mem_master_ctrl
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FW = frame_w(ADDR_W, DATA_W);
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] BIT_TOP  = BW'(FW - 1);
  localparam logic [BW-1:0] DATA_TOP = BW'(DATA_W - 1);

  state_t state, nstate;

  logic [FW-1:0]     frame;
  logic [FW-1:0]     sh;
  logic [DATA_W-1:0] rx;
  logic [BW-1:0]     bitcnt;
  logic              wr;
  logic              accept;
  logic              last_fall;
  logic              done;
  logic              gen_en;
  logic              gen_tog;
  logic              tick;
  logic              rise_stb;
  logic              fall_stb;

  assign frame = {req_write ? CMD_WRITE : CMD_READ,
                  req_addr,
                  req_write ? req_wdata : '0};

  assign accept    = req_valid && req_ready;
  assign last_fall = fall_stb && (bitcnt == '0);
  assign done      = (state == HOLD) && tick;
  assign gen_en    = (state == SHIFT) || (state == HOLD);
  assign gen_tog   = (state == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk     (clk),
    .rst     (rst),
    .en      (gen_en),
    .toggle  (gen_tog),
    .sclk    (sclk),
    .tick    (tick),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

`ifdef SPI_CS_GAP_EN
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  logic [GW-1:0] gap_cnt;

  // count down the enforced cs-high interval
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (done) begin
      gap_cnt <= GW'(CS_GAP - 1);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // next state and handshake outputs
  always_comb begin
    nstate    = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !rsp_valid;
        if (req_valid && !rsp_valid) begin
          nstate = SHIFT;
        end
      end
      SHIFT: begin
        if (last_fall) begin
          nstate = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
`ifdef SPI_CS_GAP_EN
          nstate = GAP;
`else
          nstate = IDLE;
`endif
        end
      end
      GAP: begin
`ifdef SPI_CS_GAP_EN
        if (gap_cnt == '0) begin
          nstate = IDLE;
        end
`else
        nstate = IDLE;
`endif
      end
      default: nstate = IDLE;
    endcase
  end

  // shift-out, capture and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs        <= 1'b1;
      mosi      <= 1'b0;
      sh        <= '0;
      rx        <= '0;
      bitcnt    <= '0;
      wr        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        cs     <= 1'b0;
        mosi   <= frame[FW-1];
        sh     <= {frame[FW-2:0], 1'b0};
        rx     <= '0;
        bitcnt <= BIT_TOP;
        wr     <= req_write;
      end
      if (rise_stb && bitcnt <= DATA_TOP) begin
        rx <= {rx[DATA_W-2:0], miso};
      end
      if (fall_stb) begin
        sh <= {sh[FW-2:0], 1'b0};
        if (last_fall) begin
          mosi <= 1'b0;
        end else begin
          mosi   <= sh[FW-1];
          bitcnt <= bitcnt - BW'(1);
        end
      end
      if (done) begin
        cs        <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_rdata <= wr ? '0 : rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_master_ctrl.sv
// Bench for spi_mem_master_ctrl: SPI slave memory model plus
// reference memory, per-cycle bus checks and directed requests.
module tb_spi_mem_master_ctrl;

  typedef struct packed {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
  } req_t;

`ifdef SPI_CS_GAP_EN
  localparam int MIN_HIGH = 4;
`else
  localparam int MIN_HIGH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata, rsp_rdata;
  logic        rsp_valid, busy, cs, sclk, mosi, miso;

  logic        req_valid1, req_ready1, req_write1;
  logic [7:0]  req_addr1;
  logic [15:0] req_wdata1, rsp_rdata1;
  logic        rsp_valid1, busy1, cs1, sclk1, mosi1, miso1;

  spi_mem_master_ctrl #(
    .CLK_DIV(2), .ADDR_W(8), .DATA_W(16), .CS_GAP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .cs(cs),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_mem_master_ctrl #(
    .CLK_DIV(1), .ADDR_W(8), .DATA_W(16), .CS_GAP(4)
  ) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .busy(busy1), .cs(cs1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // slave memory on the bus, and the bench's reference memory
  logic [15:0] smem [256];
  logic [15:0] ref_mem [256];
  logic [31:0] sframe;
  logic [15:0] sout;
  int          scnt;

  always @(negedge cs) begin
    scnt   = 0;
    sframe = '0;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      sframe = {sframe[30:0], mosi};
      scnt++;
      if (scnt == 16) sout = smem[sframe[7:0]];
    end
  end

  always @(negedge sclk) begin
    if (!cs && scnt >= 16 && scnt < 32) miso = sout[31-scnt];
  end

  always @(posedge cs) begin
    if (scnt == 32 && sframe[31:24] == 8'h02)
      smem[sframe[23:16]] = sframe[15:0];
  end

  // per-cycle checks and response scoreboard
  req_t        exp_q[$];
  req_t        e;
  logic        prev_cs, prev_sclk;
  int          cs_low, rises, cs_high, n_rsp, n_frames;
  logic [15:0] last_rdata;
  logic [31:0] last_frame;
  logic [15:0] want;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_pins", {27'd0, cs, sclk, mosi, rsp_valid, busy}, 32'h10);
      check("reset_rdata", {16'd0, rsp_rdata}, 32'h0);
      exp_q.delete();
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      cs_high   = 1000;
    end else begin
      check("sclk_idle_cs_high", {31'd0, cs & sclk}, 32'h0);
      if (cs !== prev_cs)
        check("cs_edge_sclk_low", {31'd0, sclk | prev_sclk}, 32'h0);
      if (!cs) check("ready_while_cs_low", {31'd0, req_ready}, 32'h0);
      if (!cs && prev_cs) begin
        check("cs_high_gap", {31'd0, cs_high >= MIN_HIGH}, 32'h1);
        cs_low = 0;
        rises  = 0;
        n_frames++;
      end
      if (!cs) begin
        cs_low++;
        if (sclk && !prev_sclk) rises++;
      end else begin
        cs_high++;
      end
      if (cs && !prev_cs) begin
        check("cs_rise_has_rsp", {31'd0, rsp_valid}, 32'h1);
        cs_high = 1;
      end
      if (rsp_valid) begin
        check("rsp_not_on_accept", {31'd0, req_valid & req_ready}, 32'h0);
        check("rsp_on_cs_rise", {30'd0, prev_cs, cs}, 32'h1);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e    = exp_q.pop_front();
          want = e.w ? 16'h0 : ref_mem[e.a];
          check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, want});
          check("cs_low_cycles", cs_low, 130);
          check("sclk_rises", rises, 32);
          check("frame_hdr", {16'd0, sframe[31:16]},
                {16'd0, e.w ? 8'h02 : 8'h03, e.a});
          if (e.w) begin
            check("frame_data", {16'd0, sframe[15:0]}, {16'd0, e.d});
            ref_mem[e.a] = e.d;
          end
        end
        last_rdata = rsp_rdata;
        last_frame = sframe;
        n_rsp++;
      end
      prev_cs   = cs;
      prev_sclk = sclk;
    end
  end

  // CLK_DIV=1 instance: fixed read pattern from a tiny slave
  logic [15:0] pat1 = 16'hA5C3;
  logic [31:0] f1;
  int          k1, c1, r1;
  logic        pcs1, psclk1;

  always @(negedge cs1) begin
    k1 = 0;
    f1 = '0;
  end

  always @(posedge sclk1) begin
    if (!cs1) begin
      f1 = {f1[30:0], mosi1};
      k1++;
    end
  end

  always @(negedge sclk1) begin
    if (!cs1 && k1 >= 16 && k1 < 32) miso1 = pat1[31-k1];
  end

  always @(negedge clk) begin
    if (rst) begin
      pcs1   = 1'b1;
      psclk1 = 1'b0;
    end else begin
      if (!cs1 && pcs1) begin
        c1 = 0;
        r1 = 0;
      end
      if (!cs1) begin
        c1++;
        if (sclk1 && !psclk1) r1++;
      end
      pcs1   = cs1;
      psclk1 = sclk1;
    end
  end

  // wait for the accepting edge with the current request fields
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        exp_q.push_back('{req_write, req_addr, req_wdata});
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_accept_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic send(input logic w, input logic [7:0] a,
                      input logic [15:0] d);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_accept("send");
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #1;
      if (n_rsp >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_rsp_timeout"}, 32'h0, 32'h1);
  endtask

  int nr0, nf0, nr_at;

  initial begin
    for (int i = 0; i < 256; i++) begin
      smem[i]    = {8'(i), ~8'(i)};
      ref_mem[i] = {8'(i), ~8'(i)};
    end
    n_rsp = 0; n_frames = 0; cs_low = 0; rises = 0; cs_high = 1000;
    last_rdata = '0; last_frame = '0; scnt = 0; sframe = '0;
    miso = 1'b0; miso1 = 1'b0; c1 = 0; r1 = 0; k1 = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0;
    req_wdata1 = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (20) begin
      @(negedge clk);
      check("idle_pins", {27'd0, cs, sclk, mosi, req_ready, rsp_valid},
            32'h12);
    end

    send(1'b1, 8'h15, 16'hBEEF);
    wait_rsp(1, "w15");
    check("w15_frame", last_frame, 32'h0215BEEF);
    check("w15_rdata", {16'd0, last_rdata}, 32'h0);

    send(1'b0, 8'h15, 16'h0);
    wait_rsp(2, "r15");
    check("r15_hdr", {16'd0, last_frame[31:16]}, 32'h0315);
    check("r15_rdata", {16'd0, last_rdata}, 32'hBEEF);

    nr0 = n_rsp;
    nf0 = n_frames;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h00;
    req_wdata = 16'h1111;
    wait_accept("b2b_first");
    req_addr  = 8'hFF;
    req_wdata = 16'h2222;
    wait_accept("b2b_second");
    nr_at = n_rsp;
    req_valid = 1'b0;
    check("b2b_second_after_rsp", nr_at, nr0 + 1);
    wait_rsp(nr0 + 2, "b2b");
    repeat (10) @(negedge clk);
    check("b2b_frames", n_frames - nf0, 2);

    send(1'b0, 8'h00, 16'h0);
    wait_rsp(nr0 + 3, "r00");
    check("r00_rdata", {16'd0, last_rdata}, 32'h1111);
    send(1'b0, 8'hFF, 16'h0);
    wait_rsp(nr0 + 4, "rff");
    check("rff_rdata", {16'd0, last_rdata}, 32'h2222);

    nr0 = n_rsp;
    send(1'b1, 8'h15, 16'h1234);
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 500; n++) begin
        @(posedge clk);
        if (scnt >= 10) begin
          hit = 1'b1;
          break;
        end
      end
      check("abort_bit10_reached", {31'd0, hit}, 32'h1);
    end
    #3;
    rst = 1'b1;
    #1;
    check("abort_async_pins", {30'd0, cs, sclk}, 32'h2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_rsp", n_rsp, nr0);
    send(1'b0, 8'h15, 16'h0);
    wait_rsp(nr0 + 1, "r15_after_abort");
    check("r15_old_value", {16'd0, last_rdata}, 32'hBEEF);

    @(posedge clk);
    #1;
    req_valid1 = 1'b1;
    req_write1 = 1'b0;
    req_addr1  = 8'h42;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
        @(negedge clk);
        if (rsp_valid1) begin
          ok = 1'b1;
          break;
        end
      end
      check("div1_rsp_seen", {31'd0, ok}, 32'h1);
      check("div1_rdata", {16'd0, rsp_rdata1}, 32'hA5C3);
      check("div1_cs_low", c1, 65);
      check("div1_rises", r1, 32);
      check("div1_hdr", {16'd0, f1[31:16]}, 32'h0342);
    end

    repeat (10) @(negedge clk);
    check("pending_rsp", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
